// File: rtl/line_follower_pkg.sv
// Shared types and helpers for the two-sensor line-follower controller.
package line_follower_pkg;

    localparam int unsigned PATTERN_WIDTH = 2;
    localparam int unsigned RUN_WIDTH     = 8;

    typedef enum logic [1:0] {
        STOP       = 2'b00,
        FORWARD    = 2'b01,
        TURN_LEFT  = 2'b10,
        TURN_RIGHT = 2'b11
    } steerStateT;

    // Sensor patterns as {sensorLeft, sensorRight}; 1 = white, 0 = black.
    localparam logic [PATTERN_WIDTH-1:0] PAT_BOTH_WHITE  = 2'b11;
    localparam logic [PATTERN_WIDTH-1:0] PAT_LEFT_BLACK  = 2'b01;
    localparam logic [PATTERN_WIDTH-1:0] PAT_RIGHT_BLACK = 2'b10;
    localparam logic [PATTERN_WIDTH-1:0] PAT_BOTH_BLACK  = 2'b00;

    // Motor enables as {motorLeft, motorRight} for each steering state.
    function automatic logic [1:0] stateToMotors(input steerStateT s);
        logic [1:0] m;
        m = 2'b00;
        case (s)
            FORWARD:    m = 2'b11;
            TURN_LEFT:  m = 2'b01;
            TURN_RIGHT: m = 2'b10;
            default:    m = 2'b00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/line_follower_filter.sv
// Stability filter: accepts a sensor pattern once it has been seen on
// FILTER_CYCLES consecutive edges; the run counter saturates.
module line_follower_filter
    import line_follower_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 1,
    parameter int unsigned WIDTH         = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample,
    output logic             accept,
    output logic [WIDTH-1:0] pattern
);

    localparam logic [RUN_WIDTH-1:0] RUN_MAX = RUN_WIDTH'(FILTER_CYCLES);

    logic [WIDTH-1:0]     last;
    logic [RUN_WIDTH-1:0] run;
    logic [RUN_WIDTH-1:0] runNext;

    always_comb begin
        runNext = RUN_WIDTH'(1);
        if (sample == last) begin
            runNext = (run >= RUN_MAX) ? RUN_MAX : run + RUN_WIDTH'(1);
        end
    end

    // Acceptance looks at the run value this edge will store.
    assign accept  = (runNext >= RUN_MAX);
    assign pattern = sample;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= '0;
            run  <= '0;
        end else begin
            last <= sample;
            run  <= runNext;
        end
    end

endmodule

// File: rtl/line_follower.sv
// Line-follower steering FSM with registered motor enables.
// Optional end-of-track sticky STOP: define LINE_FOLLOWER_STOP_LATCH_EN.
module line_follower
    import line_follower_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic sensorLeft,
    input  logic sensorRight,
    output logic motorLeft,
    output logic motorRight
);

    logic                     accept;
    logic [PATTERN_WIDTH-1:0] acceptedPattern;
    steerStateT               state;
    steerStateT               stateNext;
    logic                     frozen;
    logic [1:0]               motorsNext;

    line_follower_filter #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .WIDTH         (PATTERN_WIDTH)
    ) uFilter (
        .clk     (clk),
        .reset   (reset),
        .sample  ({sensorLeft, sensorRight}),
        .accept  (accept),
        .pattern (acceptedPattern)
    );

`ifdef LINE_FOLLOWER_STOP_LATCH_EN
    logic stopLatched;
    logic stopLatchedNext;

    // Only a 00 accepted while moving latches; the reset STOP stays live.
    always_comb begin
        stopLatchedNext = stopLatched;
        if (accept && (acceptedPattern == PAT_BOTH_BLACK) && (state != STOP)) begin
            stopLatchedNext = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stopLatched <= 1'b0;
        end else begin
            stopLatched <= stopLatchedNext;
        end
    end

    assign frozen = stopLatched;
`else
    assign frozen = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        if (accept && !frozen) begin
            case (acceptedPattern)
                PAT_BOTH_WHITE:  stateNext = FORWARD;
                PAT_LEFT_BLACK:  stateNext = TURN_LEFT;
                PAT_RIGHT_BLACK: stateNext = TURN_RIGHT;
                default:         stateNext = STOP;
            endcase
        end
        motorsNext = stateToMotors(stateNext);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= STOP;
            motorLeft  <= 1'b0;
            motorRight <= 1'b0;
        end else begin
            state      <= stateNext;
            motorLeft  <= motorsNext[1];
            motorRight <= motorsNext[0];
        end
    end

endmodule

// File: tb/tb_line_follower.sv
// Scoreboard bench: one DUT with FILTER_CYCLES=1 and one with FILTER_CYCLES=3
// share clock, reset and sensors; a streak-count model predicts both.
module tb_line_follower;

    logic clk;
    logic reset;
    logic sensorLeft;
    logic sensorRight;
    logic motorLeft1, motorRight1;
    logic motorLeft3, motorRight3;

    int nChecks = 0;
    int nFails  = 0;

    line_follower #(.FILTER_CYCLES(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .sensorLeft  (sensorLeft),
        .sensorRight (sensorRight),
        .motorLeft   (motorLeft1),
        .motorRight  (motorRight1)
    );

    line_follower #(.FILTER_CYCLES(3)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .sensorLeft  (sensorLeft),
        .sensorRight (sensorRight),
        .motorLeft   (motorLeft3),
        .motorRight  (motorRight3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: count consecutive identical samples (unbounded) and
    // accept once the streak reaches the filter length; motors follow the
    // accepted pattern bit for bit.
    int         fcOf   [2] = '{1, 3};
    int         streak [2];
    logic [1:0] lastPat[2];
    logic [1:0] expMot [2];
    bit         latched[2];
    logic [3:0] sb[$];

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            streak[i]  = 0;
            lastPat[i] = 2'b00;
            expMot[i]  = 2'b00;
            latched[i] = 1'b0;
        end
    endtask

    task automatic modelStep(input logic [1:0] pat);
        for (int i = 0; i < 2; i++) begin
            streak[i]  = (pat == lastPat[i]) ? streak[i] + 1 : 1;
            lastPat[i] = pat;
            if (streak[i] >= fcOf[i] && !latched[i]) begin
`ifdef LINE_FOLLOWER_STOP_LATCH_EN
                if (pat == 2'b00 && expMot[i] != 2'b00) latched[i] = 1'b1;
`endif
                expMot[i] = pat;
            end
        end
    endtask

    task automatic cycle(input logic [1:0] pat, input string tag);
        logic [3:0] e;
        {sensorLeft, sensorRight} = pat;
        modelStep(pat);
        sb.push_back({expMot[0], expMot[1]});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkEq({tag, "_f1"}, 8'({motorLeft1, motorRight1}), 8'(e[3:2]));
        checkEq({tag, "_f3"}, 8'({motorLeft3, motorRight3}), 8'(e[1:0]));
    endtask

    task automatic repeatCycle(input logic [1:0] pat, input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(pat, tag);
    endtask

    initial begin
        reset = 1'b0;
        {sensorLeft, sensorRight} = 2'b00;
        modelReset();

        // Reset behaviour
        #1;
        checkEq("rst_during_f1", 8'({motorLeft1, motorRight1}), 8'h0);
        checkEq("rst_during_f3", 8'({motorLeft3, motorRight3}), 8'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        cycle(2'b00, "after_rst");

        // One cycle each of 11, 01, 10, 00
        cycle(2'b11, "seq11");
        checkEq("seq11_const", 8'({motorLeft1, motorRight1}), 8'h3);
        cycle(2'b01, "seq01");
        cycle(2'b10, "seq10");
        cycle(2'b00, "seq00");

        // Glitch rejection on the 3-cycle filter
        repeatCycle(2'b11, 3, "fwd");
        repeatCycle(2'b01, 2, "glitch");
        checkEq("glitch_hold", 8'({motorLeft3, motorRight3}), 8'h3);
        cycle(2'b11, "glitch_back");
        repeatCycle(2'b01, 3, "turnl");
        checkEq("turnl_const", 8'({motorLeft3, motorRight3}), 8'h1);

        // Direct transitions
        cycle(2'b01, "direct01");
        cycle(2'b10, "direct10");
        checkEq("direct10_const", 8'({motorLeft1, motorRight1}), 8'h2);

        // Async reset between edges from TURN_RIGHT
        repeatCycle(2'b10, 3, "turnr");
        #3;
        reset = 1'b0;
        #1;
        checkEq("async_f1", 8'({motorLeft1, motorRight1}), 8'h0);
        checkEq("async_f3", 8'({motorLeft3, motorRight3}), 8'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        modelReset();

        // Saturation under a constant pattern
        repeatCycle(2'b11, 300, "sat");
        checkEq("sat_run", 8'(dut3.uFilter.run), 8'd3);

        // End-of-track: 00 then 11, then reset and resume
        repeatCycle(2'b00, 3, "stop");
        repeatCycle(2'b11, 3, "after_stop");
        #3;
        reset = 1'b0;
        #1;
        checkEq("latch_rst_f3", 8'({motorLeft3, motorRight3}), 8'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        modelReset();
        repeatCycle(2'b11, 3, "resume");
        checkEq("resume_const", 8'({motorLeft3, motorRight3}), 8'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
